uart_tx_fifo: RTL
=================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 434, giving core-clock cycles per serial bit (legal range 2..65535).
REQ-002 The block SHALL have parameter DATA_BITS, default 8, giving data bits per frame (legal range 5..8).
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 16, giving the number of FIFO entries (power of two, 2..256).
REQ-004 The block SHALL have parameter PARITY, default 0, selecting the parity mode: 0 none, 1 even, 2 odd.
REQ-005 The block SHALL have parameter STOP_BITS, default 1, giving stop bits per frame (1 or 2).
REQ-006 The block SHALL have port clk, input, 1 bit: the single core clock; all logic is clocked on its rising edge.
REQ-007 The block SHALL have port rstn, input, 1 bit: the reset, which is synchronous and active-low.
REQ-008 The block SHALL have port wr_data, input, DATA_BITS bits: the byte to enqueue.
REQ-009 The block SHALL have port wr_valid, input, 1 bit: a write request.
REQ-010 The block SHALL have port wr_ready, output, 1 bit: the FIFO can accept a write.
REQ-011 The block SHALL have port txd, output, 1 bit: the serial line, idle high.
REQ-012 The block SHALL have port busy, output, 1 bit: a frame is in progress or the FIFO is non-empty.
REQ-013 The block SHALL have port count, output, $clog2(FIFO_DEPTH)+1 bits: the current FIFO occupancy.

Function
REQ-014 The block SHALL accept a write exactly on a rising edge where wr_valid=1 and wr_ready=1; wr_ready SHALL equal (count != FIFO_DEPTH), derived from registered count.
REQ-015 A write while full SHALL be dropped silently, with FIFO contents and count unchanged.
REQ-016 The transmit FSM SHALL have states IDLE, START, DATA, PAR, STOP.
REQ-017 In IDLE with count != 0, the FSM SHALL pop the head entry into a shift register on the next edge and enter START.
REQ-018 A simultaneous push and pop SHALL leave count unchanged, and the pushed data SHALL be preserved.
REQ-019 On every clock in which the FSM is in START, DATA, PAR or STOP, txd SHALL be registered-driven according to the current state: START drives 0; DATA drives the data bits LSB first, bit index 0..DATA_BITS-1; PAR drives the parity bit, with even parity giving XOR of the data and odd parity giving its inverse; STOP drives 1 for STOP_BITS bit times.
REQ-020 Each bit SHALL last exactly CLK_DIV clocks, timed by a baud counter that reloads to 0 on every state or bit transition.
REQ-021 The FSM SHALL skip PAR when PARITY=0.
REQ-022 The frame length SHALL be (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*CLK_DIV clocks.
REQ-023 At the end of the last stop bit, if count != 0, the FSM SHALL go directly to START with the next popped entry, with no idle bit time inserted.
REQ-024 At the end of the last stop bit, if count == 0, the FSM SHALL go to IDLE.
REQ-025 Latency: a write accepted at edge N into an empty, idle block SHALL produce txd=0 from edge N+2.
REQ-026 busy SHALL be 1 whenever the state is not IDLE or count != 0.
REQ-027 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-028 count SHALL never exceed FIFO_DEPTH nor underflow below 0.

Reset
REQ-029 While rstn=0 at a rising edge, the block SHALL set: txd=1, wr_ready=1, busy=0, count=0, FSM=IDLE, pointers=0, baud counter=0.
REQ-030 A reset asserted mid-frame SHALL abort the frame, set txd=1 from the next edge, and discard all FIFO contents.
REQ-031 The block SHALL not require FIFO storage contents to be reset.

Structure
REQ-032 A shared package uart_pkg SHALL hold the tx_state_t enum (IDLE, START, DATA, PAR, STOP) and the parity constants PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2.
REQ-033 The FIFO SHALL be a sub-module sync_fifo (parameters WIDTH, DEPTH; ports push, pop, full, empty, count), reusable by the UART receiver.
REQ-034 The block SHALL have no PLL or clock generation; clk is the core clock supplied at top level.

Verification
REQ-035 With CLK_DIV=4, PARITY=0, STOP_BITS=1, writing 0x55 once -> txd carries 0,1,0,1,0,1,0,1,0,1, each held 4 clocks, txd=0 from edge N+2, and busy drops after 40 clocks of frame.
REQ-036 With PARITY=1, writing 0x07 -> parity bit 1; with PARITY=2, writing 0x07 -> parity bit 0; with STOP_BITS=2, the stop level is held 2*CLK_DIV clocks.
REQ-037 Writing 0xA3 then 0x3C on consecutive clocks with CLK_DIV=4, PARITY=0, STOP_BITS=1 -> two frames back-to-back totalling 80 clocks with no idle gap, and data order preserved.
REQ-038 With FIFO_DEPTH=16, driving wr_valid=1 for 18 consecutive cycles from empty -> exactly 17 writes accepted, count=16, wr_ready=0 on the 18th cycle, and the 18th byte never transmitted.
REQ-039 Asserting rstn=0 for 1 clock in the middle of the DATA state with 3 entries queued -> txd=1, count=0, busy=0 after the edge, and no further frames transmitted.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, parity modes and the parity helper.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} tx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Zero padding of narrow words leaves the XOR unchanged.
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    return (mode == PAR_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; shared by the UART transmitter and receiver.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a FIFO; frames are sent back-to-back while entries remain.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 434,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [DATA_BITS-1:0]          wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  tx_state_t            state;
  logic [15:0]          baud;
  logic [2:0]           bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] head;
  logic                 par_bit;
  logic                 full;
  logic                 empty;
  logic                 pop;
  logic                 baud_end;
  logic                 bit_last;
  logic                 stop_last;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (wr_valid),
    .wdata (wr_data),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign baud_end  = (baud == 16'(CLK_DIV - 1));
  assign bit_last  = (bit_idx == 3'(DATA_BITS - 1));
  assign stop_last = (stop_idx == 1'(STOP_BITS - 1));
  assign pop       = !empty && ((state == IDLE) || (state == STOP && baud_end && stop_last));
  assign wr_ready  = !full;
  assign busy      = (state != IDLE) || !empty;

  // Frame data path: loaded on every pop, shifted LSB-first through DATA.
  always_ff @(posedge clk) begin
    if (pop) begin
      shreg   <= head;
      par_bit <= parity_bit(8'(head), PARITY);
    end else if (state == DATA && baud_end) begin
      shreg <= shreg >> 1;
    end
  end

  // txd is registered from the current state, so the line trails the FSM by one clock.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      baud     <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      txd      <= 1'b1;
    end else begin
      case (state)
        START:   txd <= 1'b0;
        DATA:    txd <= shreg[0];
        PAR:     txd <= par_bit;
        default: txd <= 1'b1;
      endcase

      if (state == IDLE || baud_end) baud <= '0;
      else                           baud <= baud + 16'd1;

      case (state)
        IDLE: begin
          if (!empty) state <= START;
        end
        START: begin
          if (baud_end) begin
            state   <= DATA;
            bit_idx <= '0;
          end
        end
        DATA: begin
          if (baud_end) begin
            if (bit_last) begin
              state    <= (PARITY != PAR_NONE) ? PAR : STOP;
              stop_idx <= 1'b0;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        PAR: begin
          if (baud_end) begin
            state    <= STOP;
            stop_idx <= 1'b0;
          end
        end
        STOP: begin
          if (baud_end) begin
            if (!stop_last) stop_idx <= 1'b1;
            else            state <= empty ? IDLE : START;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
